// File: rtl/prog_loader.sv
// prog_loader: writer side of the instruction-ROM port.
// Receives a byte stream (count header followed by LO/HI byte pairs), packs each pair
// into a 9-bit instruction, writes it into instruction memory from address 0, then
// releases the core and counts cycles until the core reports halt.
module prog_loader #(
  parameter int IW        = 9,
  parameter int AW        = 16,
  parameter int MAX_WORDS = 1024,
  parameter int START_CYC = 2
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [IW-1:0] wr_data,
  output logic          core_start,
  input  logic          core_halt,
  input  logic          clear,
  output logic          done,
  output logic          err,
  output logic [15:0]   run_cycles
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HDR_HI = 3'd1;
  localparam logic [2:0] S_INS_LO = 3'd2;
  localparam logic [2:0] S_INS_HI = 3'd3;
  localparam logic [2:0] S_START  = 3'd4;
  localparam logic [2:0] S_RUN    = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_ERR    = 3'd7;

  // START lasts the write cycle plus START_CYC further cycles, so the counter
  // runs 0..START_CYC before handing over to RUN.
  localparam logic [7:0] START_LAST = 8'(START_CYC);

  logic [2:0]    state;
  logic [7:0]    cnt_lo;
  logic [15:0]   word_cnt;
  logic [AW-1:0] word_idx;
  logic [7:0]    lo_byte;
  logic [7:0]    start_cnt;

  logic          accept;
  logic [15:0]   hdr_n;
  logic          last_word;

  // Byte handshake, header decode and last-word detection.
  always_comb begin
    rx_ready  = reset && ((state == S_IDLE) || (state == S_HDR_HI) ||
                          (state == S_INS_LO) || (state == S_INS_HI));
    accept    = rx_valid && rx_ready;
    hdr_n     = {rx_data, cnt_lo};
    last_word = ((32'(word_idx) + 32'd1) == 32'(word_cnt));
    core_start = !((state == S_RUN) || (state == S_DONE));
    done      = (state == S_DONE);
    err       = (state == S_ERR);
  end

  // Loader FSM: header capture, word packing/writing, start pulse and run counter.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt_lo     <= '0;
      word_cnt   <= '0;
      word_idx   <= '0;
      lo_byte    <= '0;
      start_cnt  <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      run_cycles <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            cnt_lo <= rx_data;
            state  <= S_HDR_HI;
          end
        end
        S_HDR_HI: begin
          if (accept) begin
            word_cnt <= hdr_n;
            if (hdr_n == 16'd0) begin
              start_cnt <= '0;
              state     <= S_START;
            end else if (32'(hdr_n) > 32'(MAX_WORDS)) begin
              state <= S_ERR;
            end else begin
              state <= S_INS_LO;
            end
          end
        end
        S_INS_LO: begin
          if (accept) begin
            lo_byte <= rx_data;
            state   <= S_INS_HI;
          end
        end
        S_INS_HI: begin
          if (accept) begin
            if (rx_data[7:1] != 7'd0) begin
              state <= S_ERR;
            end else begin
              wr_en    <= 1'b1;
              wr_addr  <= word_idx;
              wr_data  <= IW'({rx_data[0], lo_byte});
              word_idx <= word_idx + 1'b1;
              if (last_word) begin
                start_cnt <= '0;
                state     <= S_START;
              end else begin
                state <= S_INS_LO;
              end
            end
          end
        end
        S_START: begin
          if (start_cnt == START_LAST) begin
            state <= S_RUN;
          end else begin
            start_cnt <= start_cnt + 8'd1;
          end
        end
        S_RUN: begin
          if (core_halt) begin
            state <= S_DONE;
          end else if (run_cycles != 16'hFFFF) begin
            run_cycles <= run_cycles + 16'd1;
          end
        end
        S_DONE, S_ERR: begin
          if (clear) begin
            state      <= S_IDLE;
            run_cycles <= '0;
            word_idx   <= '0;
            word_cnt   <= '0;
          end
        end
        default: state <= S_ERR;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed self-checking bench for prog_loader.
module tb_prog_loader;

  logic        CLK = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [8:0]  wr_data;
  logic        core_start;
  logic        core_halt;
  logic        clear;
  logic        done;
  logic        err;
  logic [15:0] run_cycles;

  int vectors = 0;
  int miscompares = 0;
  int nw = 0;
  logic [15:0] wa [0:63];
  logic [8:0]  wd [0:63];

  prog_loader dut (
    .CLK(CLK), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .core_start(core_start),
    .core_halt(core_halt), .clear(clear), .done(done), .err(err), .run_cycles(run_cycles)
  );

  // Free-running clock.
  always #5 CLK = ~CLK;

  // Logs every instruction-memory write, sampled away from the active edge.
  always @(negedge CLK) begin
    if (wr_en === 1'b1 && nw < 64) begin
      wa[nw] = wr_addr;
      wd[nw] = wr_data;
      nw = nw + 1;
    end
  end

  // Absolute time limit so the run can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  // Presents one byte and holds it until the loader takes it (bounded).
  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && t < 50) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 50) begin
      vectors++; miscompares++;
      $display("[TB] FAIL send_byte_timeout: byte %0h not accepted, rx_ready %0b want 1", b, rx_ready);
    end
    @(negedge CLK);
    rx_valid = 1'b0;
  endtask

  // Waits (bounded) for the core to be released.
  task automatic wait_run();
    int t;
    t = 0;
    while (core_start !== 1'b0 && t < 50) begin
      @(negedge CLK);
      t++;
    end
    vectors++;
    if (core_start !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL wait_run: core_start %0b want 0 within 50 cycles", core_start);
    end
  endtask

  task automatic do_clear(input string tag);
    clear = 1'b1;
    @(negedge CLK);
    clear = 1'b0;
    vectors++;
    if (done !== 1'b0 || err !== 1'b0 || run_cycles !== 16'd0 || rx_ready !== 1'b1 || core_start !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL %s_clear: done %0b err %0b run %0d rdy %0b start %0b want 0 0 0 1 1",
               tag, done, err, run_cycles, rx_ready, core_start);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; core_halt = 1'b0; clear = 1'b0;
    #1;
    vectors++;
    if (rx_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rx_ready: got %0b want 0", rx_ready); end
    vectors++;
    if (wr_en !== 1'b0 || wr_addr !== 16'd0 || wr_data !== 9'd0) begin
      miscompares++; $display("[TB] FAIL reset_wr: en %0b addr %0h data %0h want 0 0 0", wr_en, wr_addr, wr_data);
    end
    vectors++;
    if (core_start !== 1'b1 || done !== 1'b0 || err !== 1'b0 || run_cycles !== 16'd0) begin
      miscompares++; $display("[TB] FAIL reset_ctl: start %0b done %0b err %0b run %0d want 1 0 0 0",
                              core_start, done, err, run_cycles);
    end
    @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    vectors++;
    if (rx_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL post_reset_rx_ready: got %0b want 1", rx_ready); end
  endtask

  task automatic test_basic_load();
    logic [8:0] exp_d [0:2];
    int base;
    exp_d[0] = 9'h1A5; exp_d[1] = 9'h0FF; exp_d[2] = 9'h100;
    base = nw;
    core_halt = 1'b1;
    send_byte(8'h03); send_byte(8'h00);
    send_byte(8'hA5); send_byte(8'h01);
    send_byte(8'hFF); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h01);
    vectors++;
    if (wr_en !== 1'b1 || wr_addr !== 16'd2 || wr_data !== 9'h100) begin
      miscompares++; $display("[TB] FAIL basic_last_write: en %0b addr %0h data %0h want 1 2 100", wr_en, wr_addr, wr_data);
    end
    vectors++;
    if (core_start !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_start_w0: got %0b want 1", core_start); end
    @(negedge CLK);
    vectors++;
    if (core_start !== 1'b1 || wr_en !== 1'b0) begin
      miscompares++; $display("[TB] FAIL basic_start_w1: start %0b wr_en %0b want 1 0", core_start, wr_en);
    end
    @(negedge CLK);
    vectors++;
    if (core_start !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_start_w2: got %0b want 1", core_start); end
    @(negedge CLK);
    vectors++;
    if (core_start !== 1'b0 || done !== 1'b0) begin
      miscompares++; $display("[TB] FAIL basic_start_w3: start %0b done %0b want 0 0", core_start, done);
    end
    core_halt = 1'b0;
    repeat (3) @(negedge CLK);
    vectors++;
    if (run_cycles !== 16'd3 || done !== 1'b0) begin
      miscompares++; $display("[TB] FAIL basic_running: run %0d done %0b want 3 0", run_cycles, done);
    end
    core_halt = 1'b1;
    @(negedge CLK);
    core_halt = 1'b0;
    vectors++;
    if (done !== 1'b1 || run_cycles !== 16'd3) begin
      miscompares++; $display("[TB] FAIL basic_done: done %0b run %0d want 1 3", done, run_cycles);
    end
    @(negedge CLK);
    vectors++;
    if (done !== 1'b1 || run_cycles !== 16'd3) begin
      miscompares++; $display("[TB] FAIL basic_frozen: done %0b run %0d want 1 3", done, run_cycles);
    end
    vectors++;
    if (nw - base !== 3) begin miscompares++; $display("[TB] FAIL basic_write_count: got %0d want 3", nw - base); end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (wa[base+i] !== 16'(i) || wd[base+i] !== exp_d[i]) begin
        miscompares++; $display("[TB] FAIL basic_write%0d: addr %0h data %0h want %0h %0h", i, wa[base+i], wd[base+i], i, exp_d[i]);
      end
    end
    do_clear("basic");
  endtask

  task automatic test_gapped_load();
    logic [7:0] bytes [0:7];
    logic [8:0] exp_d [0:2];
    int base;
    bytes[0] = 8'h03; bytes[1] = 8'h00; bytes[2] = 8'hA5; bytes[3] = 8'h01;
    bytes[4] = 8'hFF; bytes[5] = 8'h00; bytes[6] = 8'h00; bytes[7] = 8'h01;
    exp_d[0] = 9'h1A5; exp_d[1] = 9'h0FF; exp_d[2] = 9'h100;
    base = nw;
    for (int i = 0; i < 8; i++) begin
      send_byte(bytes[i]);
      if (i != 7) @(negedge CLK);
    end
    wait_run();
    core_halt = 1'b1;
    @(negedge CLK);
    core_halt = 1'b0;
    vectors++;
    if (done !== 1'b1 || run_cycles !== 16'd0) begin
      miscompares++; $display("[TB] FAIL gapped_done: done %0b run %0d want 1 0", done, run_cycles);
    end
    vectors++;
    if (nw - base !== 3) begin miscompares++; $display("[TB] FAIL gapped_write_count: got %0d want 3", nw - base); end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (wa[base+i] !== 16'(i) || wd[base+i] !== exp_d[i]) begin
        miscompares++; $display("[TB] FAIL gapped_write%0d: addr %0h data %0h want %0h %0h", i, wa[base+i], wd[base+i], i, exp_d[i]);
      end
    end
    do_clear("gapped");
  endtask

  task automatic test_zero_count();
    int base;
    base = nw;
    send_byte(8'h00); send_byte(8'h00);
    wait_run();
    repeat (5) @(negedge CLK);
    core_halt = 1'b1;
    @(negedge CLK);
    core_halt = 1'b0;
    vectors++;
    if (done !== 1'b1 || run_cycles !== 16'd5) begin
      miscompares++; $display("[TB] FAIL zero_done: done %0b run %0d want 1 5", done, run_cycles);
    end
    vectors++;
    if (nw - base !== 0) begin miscompares++; $display("[TB] FAIL zero_no_write: got %0d writes want 0", nw - base); end
    do_clear("zero");
  endtask

  task automatic test_too_long();
    int base;
    base = nw;
    send_byte(8'h01); send_byte(8'h04);
    vectors++;
    if (err !== 1'b1 || rx_ready !== 1'b0 || core_start !== 1'b1) begin
      miscompares++; $display("[TB] FAIL toolong_err: err %0b rdy %0b start %0b want 1 0 1", err, rx_ready, core_start);
    end
    repeat (3) @(negedge CLK);
    vectors++;
    if (err !== 1'b1 || nw - base !== 0) begin
      miscompares++; $display("[TB] FAIL toolong_sticky: err %0b writes %0d want 1 0", err, nw - base);
    end
    do_clear("toolong");
  endtask

  task automatic test_max_count();
    send_byte(8'h00); send_byte(8'h04);
    vectors++;
    if (err !== 1'b0 || rx_ready !== 1'b1) begin
      miscompares++; $display("[TB] FAIL max_count_ok: err %0b rdy %0b want 0 1", err, rx_ready);
    end
    reset = 1'b0;
    @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_bad_hi();
    int base;
    base = nw;
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h01);
    send_byte(8'h22); send_byte(8'h02);
    vectors++;
    if (err !== 1'b1 || rx_ready !== 1'b0) begin
      miscompares++; $display("[TB] FAIL badhi_err: err %0b rdy %0b want 1 0", err, rx_ready);
    end
    repeat (3) @(negedge CLK);
    vectors++;
    if (nw - base !== 1 || wa[base] !== 16'd0 || wd[base] !== 9'h111) begin
      miscompares++; $display("[TB] FAIL badhi_writes: count %0d addr %0h data %0h want 1 0 111", nw - base, wa[base], wd[base]);
    end
    do_clear("badhi");
  endtask

  task automatic test_reset_midway();
    int base;
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h33); send_byte(8'h00);
    send_byte(8'h44);
    reset = 1'b0;
    #1;
    vectors++;
    if (rx_ready !== 1'b0 || wr_en !== 1'b0 || wr_addr !== 16'd0 || wr_data !== 9'd0 || core_start !== 1'b1) begin
      miscompares++; $display("[TB] FAIL midload_reset: rdy %0b en %0b addr %0h data %0h start %0b want 0 0 0 0 1",
                              rx_ready, wr_en, wr_addr, wr_data, core_start);
    end
    @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    base = nw;
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h55); send_byte(8'h01);
    wait_run();
    vectors++;
    if (nw - base !== 1 || wa[base] !== 16'd0 || wd[base] !== 9'h155) begin
      miscompares++; $display("[TB] FAIL reload_write: count %0d addr %0h data %0h want 1 0 155", nw - base, wa[base], wd[base]);
    end
    repeat (2) @(negedge CLK);
    vectors++;
    if (run_cycles !== 16'd2) begin miscompares++; $display("[TB] FAIL midrun_count: got %0d want 2", run_cycles); end
    reset = 1'b0;
    #1;
    vectors++;
    if (core_start !== 1'b1 || run_cycles !== 16'd0 || done !== 1'b0 || rx_ready !== 1'b0 || wr_en !== 1'b0) begin
      miscompares++; $display("[TB] FAIL midrun_reset: start %0b run %0d done %0b rdy %0b en %0b want 1 0 0 0 0",
                              core_start, run_cycles, done, rx_ready, wr_en);
    end
    @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    vectors++;
    if (rx_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL midrun_release: rdy %0b want 1", rx_ready); end
  endtask

  // Runs every scenario in order, then reports.
  initial begin
    test_reset();
    test_basic_load();
    test_gapped_load();
    test_zero_count();
    test_too_long();
    test_max_count();
    test_bad_hi();
    test_reset_midway();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
